// File: rtl/int_port_widener_if.sv
// ---------------------------------------------------------------------------
// int_port_widener_if
// Purpose : bundles the two valid/ready channels of int_port_widener.
//           The producer/consumer side (testbench or surrounding logic) uses
//           the master modport; the widening stage uses the slave modport.
// Signals :
//   in_valid / in_ready   input channel handshake
//   in_type               00 byte, 01 byte unsigned, 10 shortint, 11 shortint unsigned
//   in_data   [15:0]      payload; byte types use [7:0]
//   out_valid / out_ready output channel handshake
//   out_data  [OUT_W-1:0] extended value at FIFO head
//   out_type  [1:0]       type tag of FIFO head
//   out_neg               sign bit of out_data
// ---------------------------------------------------------------------------
interface int_port_widener_if #(
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_type;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_type;
    logic             out_neg;

    modport master (
        output in_valid, in_type, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_type, out_neg
    );

    modport slave (
        input  in_valid, in_type, in_data, out_ready,
        output in_ready, out_valid, out_data, out_type, out_neg
    );
endinterface

// File: rtl/int_port_widener.sv
// ---------------------------------------------------------------------------
// int_port_widener
// Purpose : accepts a tagged 8/16-bit integer over valid/ready, sign- or
//           zero-extends it to OUT_W bits according to its type tag and
//           queues the result in a DEPTH-entry FIFO for a valid/ready
//           consumer. Keeps a wrapping count of accepted words.
// Ports   :
//   clk      single clock, rising edge
//   rst_n    synchronous active-low reset
//   bus      int_port_widener_if.slave (input and output channels)
//   acc_cnt  accepted input words, modulo 2**CNT_W
//   err      sticky byte width-check error
// Options : define PORT_WIDEN_STRICT_EN to check that the unused upper byte
//           of byte-typed words is a proper extension of the lower byte.
//           Without it err is tied 0 and no check logic exists.
// ---------------------------------------------------------------------------
module int_port_widener #(
    parameter int OUT_W = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    int_port_widener_if.slave bus,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [OUT_W-1:0] data_mem [DEPTH];
    logic [1:0]       type_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OUT_W-1:0] ext;
    logic             push;
    logic             pop;

    // Acceptance depends only on registered occupancy, so a full FIFO
    // rejects even when the consumer pops in the same cycle.
    assign bus.in_ready  = rst_n & (occ < FULL_OCC);
    assign bus.out_valid = (occ != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Empty FIFO presents zeros so reset shows a clean output bus.
    assign bus.out_data = bus.out_valid ? data_mem[rd_ptr] : '0;
    assign bus.out_type = bus.out_valid ? type_mem[rd_ptr] : 2'b00;
    assign bus.out_neg  = bus.out_data[OUT_W-1];

    // Size casts of signed operands sign-extend, unsigned ones zero-extend;
    // this also stays legal at OUT_W = 16 where a replication count is 0.
    always_comb begin
        ext = '0;
        case (bus.in_type)
            2'b00:   ext = OUT_W'($signed(bus.in_data[7:0]));
            2'b01:   ext = OUT_W'(bus.in_data[7:0]);
            2'b10:   ext = OUT_W'($signed(bus.in_data));
            default: ext = OUT_W'(bus.in_data);
        endcase
    end

    // Storage array: written only on accepted words, which cannot happen
    // during reset because in_ready is held low then.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= ext;
            type_mem[wr_ptr] <= bus.in_type;
        end
    end

    // Pointers, occupancy and accepted-word counter. Simultaneous push and
    // pop leaves occupancy unchanged; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            acc_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef PORT_WIDEN_STRICT_EN
    logic byte_bad;

    // A byte word is malformed when its upper byte is not the extension of
    // bit 7 (signed) or not zero (unsigned). The word is still queued.
    always_comb begin
        byte_bad = 1'b0;
        case (bus.in_type)
            2'b00:   byte_bad = (bus.in_data[15:8] != {8{bus.in_data[7]}});
            2'b01:   byte_bad = (bus.in_data[15:8] != 8'h00);
            default: byte_bad = 1'b0;
        endcase
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (push && byte_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_int_port_widener.sv
// ---------------------------------------------------------------------------
// tb_int_port_widener
// Directed bench for int_port_widener. Each accepted input word pushes its
// reference-model extension onto a scoreboard queue; the FIFO head is
// compared against the queue front every cycle and popped on output
// transfers. A 4-bit counter width is used so counter wrap is reachable.
// ---------------------------------------------------------------------------
module tb_int_port_widener;
    localparam int OUT_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] d;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] acc_cnt;
    logic             err;

    int tests = 0;
    int fails = 0;

    entry_t           sb[$];
    logic [CNT_W-1:0] exp_acc;
    logic             exp_err;

    int_port_widener_if #(.OUT_W(OUT_W)) bus ();

    int_port_widener #(
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .acc_cnt (acc_cnt),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Reference extension built from signed integer assignment.
    function automatic logic [31:0] extend(input logic [1:0] t, input logic [15:0] d);
        logic signed [7:0]  sb8;
        logic signed [15:0] sb16;
        int v;
        v = 0;
        case (t)
            2'b00: begin sb8 = d[7:0]; v = sb8; end
            2'b01: v = {24'd0, d[7:0]};
            2'b10: begin sb16 = d; v = sb16; end
            default: v = {16'd0, d};
        endcase
        return v;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput();
        logic exp_ready;
        exp_ready = rst_n && (sb.size() < DEPTH);
        checkVal("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        checkVal("out_valid", 64'(bus.out_valid), 64'(sb.size() > 0));
        if (sb.size() > 0) begin
            checkVal("out_data", 64'(bus.out_data), 64'(sb[0].d));
            checkVal("out_type", 64'(bus.out_type), 64'(sb[0].t));
            checkVal("out_neg", 64'(bus.out_neg), 64'(sb[0].d[31]));
        end
        checkVal("acc_cnt", 64'(acc_cnt), 64'(exp_acc));
        checkVal("err", 64'(err), 64'(exp_err));
    endtask

    // Drive one cycle of inputs, check outputs, then advance the model
    // across the clock edge.
    task automatic applyStimulus(input logic rst, input logic iv, input logic [1:0] t,
                                 input logic [15:0] d, input logic ordy);
        logic push;
        logic pop;
        entry_t e;
        rst_n         = rst;
        bus.in_valid  = iv;
        bus.in_type   = t;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #2;
        checkOutput();
        push = rst && iv && (sb.size() < DEPTH);
        pop  = ordy && (sb.size() > 0);
        if (!rst) begin
            sb.delete();
            exp_acc = '0;
            exp_err = 1'b0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                e.t = t;
                e.d = extend(t, d);
                sb.push_back(e);
                exp_acc = exp_acc + CNT_W'(1);
`ifdef PORT_WIDEN_STRICT_EN
                if ((t == 2'b00 && d[15:8] != {8{d[7]}}) || (t == 2'b01 && d[15:8] != 8'h00))
                    exp_err = 1'b1;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_acc       = '0;
        exp_err       = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_type   = 2'b00;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, including the zeroed output bus.
        checkVal("rst_out_data", 64'(bus.out_data), 64'd0);
        checkVal("rst_out_type", 64'(bus.out_type), 64'd0);
        checkVal("rst_out_neg", 64'(bus.out_neg), 64'd0);
        applyStimulus(1'b0, 1'b1, 2'b00, 16'h0001, 1'b1);

        // Single words of each type, one-cycle latency.
        applyStimulus(1'b1, 1'b1, 2'b00, 16'h00FF, 1'b1);
        checkVal("lat_valid", 64'(bus.out_valid), 64'd1);
        checkVal("lat_data", 64'(bus.out_data), 64'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b1, 2'b01, 16'h00FE, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b10, 16'hFFFD, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b11, 16'hFFFC, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b00, 16'h007F, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b00, 16'h0080, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b10, 16'h7FFF, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);

        // Fill with consumer stalled: 4 accepted, rest rejected.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b1, 2'(i), 16'(16'h8180 + i), 1'b0);
        checkVal("full_acc", 64'(acc_cnt), 64'd11);
        // Full FIFO with simultaneous pop still rejects this cycle.
        applyStimulus(1'b1, 1'b1, 2'b10, 16'h1234, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);

        // Streaming with simultaneous push/pop; wraps the counter.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b1, 2'(i + 1), 16'($urandom_range(0, 65535)), 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);

        // Three words queued, then reset mid-operation.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 2'b10, 16'(16'hF000 + i), 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b10, 16'h5555, 1'b1);
        checkVal("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        checkVal("mid_rst_acc", 64'(acc_cnt), 64'd0);
        applyStimulus(1'b1, 1'b1, 2'b11, 16'h8001, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);

        // Malformed byte words: err only with the strict option.
        applyStimulus(1'b1, 1'b1, 2'b00, 16'h12FF, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b01, 16'h01FE, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
